byte_word_packer: RTL

- Stream packer that accumulates byte-wide input beats into a LANES-byte output word.
- Byte 0 lands in the least-significant lane, so a full word of bytes b0..b3 equals b0 | b1<<8 | b2<<16 | b3<<24.
- A broadcast request replicates one byte across all lanes that are still empty, i.e. { LANES { byte } } when the word is empty.
- Sits directly upstream of the word-wide replication/compare logic and supplies its 32-bit operand.

---
 rtl/byte_word_packer.sv | 109 ++++++++++
 1 files changed

// File: rtl/byte_word_packer.sv
// Byte-to-word stream packer: gathers byte beats LSB-lane first into a LANES-wide
// word, with partial flush (in_last) and fill-remaining-lanes broadcast (in_bcast).
module byte_word_packer #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      in_bcast,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BYTE_W-1:0]   out_data,
  output logic [LANES-1:0]          out_keep,
  output logic [15:0]               word_count
);

  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_W = LANES * BYTE_W;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d, acc_ins;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]  out_keep_q, out_keep_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              accept, xfer, complete;
  logic [WORD_W-1:0] word;
  logic [LANES-1:0]  keep;

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign word_count = word_count_q;

  always_comb begin
    xfer     = out_valid_q && out_ready;
    accept   = in_valid && in_ready;
    complete = accept && (in_bcast || in_last || (cnt_q == LAST_LANE));

    // Lanes below cnt come from the accumulator, lane cnt is the new byte, and
    // lanes above are either zero or the broadcast byte.
    word    = '0;
    keep    = '0;
    acc_ins = acc_q;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(cnt_q)) begin
        word[i*BYTE_W +: BYTE_W] = acc_q[i*BYTE_W +: BYTE_W];
        keep[i] = 1'b1;
      end else if (i == int'(cnt_q)) begin
        word[i*BYTE_W +: BYTE_W]    = in_data;
        acc_ins[i*BYTE_W +: BYTE_W] = in_data;
        keep[i] = 1'b1;
      end else if (in_bcast) begin
        word[i*BYTE_W +: BYTE_W] = in_data;
        keep[i] = 1'b1;
      end
    end

    cnt_d = cnt_q;
    acc_d = acc_q;
    if (accept) begin
      if (complete) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_ins;
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_keep_d  = keep;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    word_count_d = xfer ? word_count_q + 16'd1 : word_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      word_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      word_count_q <= word_count_d;
    end
  end

endmodule
